// File: rtl/expr_eval_if.sv
`default_nettype none
// ============================================================================
// Module      : expr_eval_if
// Description : Character-stream bundle between a character source and the
//               expression evaluator.
//               master : drives in / in_valid, observes result / done / error
//               slave  : consumes in / in_valid, drives result / done / error
//               Signals:
//                 in       [7:0]        ASCII character
//                 in_valid              in is consumed on a rising edge when 1
//                 result   [WIDTH-1:0]  value of the last terminated expression
//                 done                  one-cycle termination pulse
//                 error                 last terminated expression was malformed
// Revision    : 1.0 - initial release
// ============================================================================
interface expr_eval_if #(
    parameter int WIDTH = 16
);
    logic [7:0]       in;
    logic             in_valid;
    logic [WIDTH-1:0] result;
    logic             done;
    logic             error;

    modport master (
        output in,
        output in_valid,
        input  result,
        input  done,
        input  error
    );

    modport slave (
        input  in,
        input  in_valid,
        output result,
        output done,
        output error
    );
endinterface
`default_nettype wire

// File: rtl/expr_eval.sv
`default_nettype none
// ============================================================================
// Module      : expr_eval
// Description : Evaluates expressions of the form digit (op digit)* '=' from
//               an ASCII stream, op in {'+','*'}, '*' binding tighter than
//               '+'. All arithmetic is modulo 2^WIDTH. On '=' the value (or an
//               error flag for a malformed expression) is registered and done
//               pulses for one cycle.
// Ports       : clk    - system clock, rising edge
//               clr_n  - synchronous active-low reset
//               bus    - expr_eval_if.slave (in, in_valid, result, done, error)
// Options     : EXPR_EVAL_MULTIDIGIT_EN - when defined, a digit following a
//               digit extends the operand (num = num*10 + d); otherwise it is
//               a syntax error.
// Revision    : 1.0 - initial release
// ============================================================================
module expr_eval #(
    parameter int WIDTH = 16
) (
    input  wire logic   clk,
    input  wire logic   clr_n,
    expr_eval_if.slave  bus
);
    localparam logic [7:0]       CH_ZERO = 8'h30;
    localparam logic [7:0]       CH_NINE = 8'h39;
    localparam logic [7:0]       CH_ADD  = 8'h2B;
    localparam logic [7:0]       CH_MUL  = 8'h2A;
    localparam logic [7:0]       CH_TERM = 8'h3D;
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

    typedef enum logic [1:0] {
        EXP_NUM = 2'd0,
        EXP_OP  = 2'd1,
        ERR     = 2'd2
    } state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] sum,    sum_n;
    logic [WIDTH-1:0] prod,   prod_n;
    logic [WIDTH-1:0] num,    num_n;
    logic [WIDTH-1:0] result, result_n;
    logic             error,  error_n;
    logic             done,   done_n;

    logic             is_digit;
    logic [WIDTH-1:0] digit;
    logic [WIDTH-1:0] term;

    // ASCII '0'..'9' occupy 0x30..0x39, so the low nibble is the digit value.
    assign is_digit = (bus.in >= CH_ZERO) && (bus.in <= CH_NINE);
    assign digit    = {{(WIDTH-4){1'b0}}, bus.in[3:0]};
    // Value of the current term once the pending operand is folded in.
    assign term     = prod * num;

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            state  <= EXP_NUM;
            sum    <= '0;
            prod   <= ONE;
            num    <= '0;
            result <= '0;
            error  <= 1'b0;
            done   <= 1'b0;
        end else begin
            state  <= state_n;
            sum    <= sum_n;
            prod   <= prod_n;
            num    <= num_n;
            result <= result_n;
            error  <= error_n;
            done   <= done_n;
        end
    end

    always_comb begin
        state_n  = state;
        sum_n    = sum;
        prod_n   = prod;
        num_n    = num;
        result_n = result;
        error_n  = error;
        done_n   = 1'b0;

        if (bus.in_valid) begin
            case (state)
                EXP_NUM: begin
                    if (is_digit) begin
                        num_n   = digit;
                        state_n = EXP_OP;
                    end else if (bus.in == CH_TERM) begin
                        // Empty expression or trailing operator.
                        result_n = '0;
                        error_n  = 1'b1;
                        done_n   = 1'b1;
                        sum_n    = '0;
                        prod_n   = ONE;
                        num_n    = '0;
                        state_n  = EXP_NUM;
                    end else begin
                        state_n = ERR;
                    end
                end
                EXP_OP: begin
                    if (bus.in == CH_MUL) begin
                        prod_n  = term;
                        state_n = EXP_NUM;
                    end else if (bus.in == CH_ADD) begin
                        sum_n   = sum + term;
                        prod_n  = ONE;
                        state_n = EXP_NUM;
                    end else if (bus.in == CH_TERM) begin
                        result_n = sum + term;
                        error_n  = 1'b0;
                        done_n   = 1'b1;
                        sum_n    = '0;
                        prod_n   = ONE;
                        num_n    = '0;
                        state_n  = EXP_NUM;
`ifdef EXPR_EVAL_MULTIDIGIT_EN
                    end else if (is_digit) begin
                        // num*10 as shift-and-add.
                        num_n   = (num << 3) + (num << 1) + digit;
                        state_n = EXP_OP;
`endif
                    end else begin
                        state_n = ERR;
                    end
                end
                ERR: begin
                    if (bus.in == CH_TERM) begin
                        result_n = '0;
                        error_n  = 1'b1;
                        done_n   = 1'b1;
                        sum_n    = '0;
                        prod_n   = ONE;
                        num_n    = '0;
                        state_n  = EXP_NUM;
                    end
                end
                default: begin
                    state_n = EXP_NUM;
                end
            endcase
        end
    end

    assign bus.result = result;
    assign bus.error  = error;
    assign bus.done   = done;
endmodule
`default_nettype wire

// File: tb/tb_expr_eval.sv
`default_nettype none
// ============================================================================
// Module      : tb_expr_eval
// Description : Directed testbench for expr_eval. Two instances (WIDTH=16 and
//               WIDTH=8) receive the same character stream; expected values
//               are hand-computed constants.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_expr_eval;
    logic clk;
    logic clr_n;
    int   checks;
    int   errors;

    expr_eval_if #(.WIDTH(16)) bus16 ();
    expr_eval_if #(.WIDTH(8))  bus8  ();

    expr_eval #(.WIDTH(16)) dut16 (
        .clk   (clk),
        .clr_n (clr_n),
        .bus   (bus16.slave)
    );

    expr_eval #(.WIDTH(8)) dut8 (
        .clk   (clk),
        .clr_n (clr_n),
        .bus   (bus8.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Drive one character to both instances and return 1 time unit after
    // the consuming edge, when the registered outputs reflect it.
    task automatic put(input logic [7:0] c);
        bus16.in       = c;
        bus16.in_valid = 1'b1;
        bus8.in        = c;
        bus8.in_valid  = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus16.in       = 8'hxx;
        bus16.in_valid = 1'b0;
        bus8.in        = 8'hxx;
        bus8.in_valid  = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Send s; no done may appear before its final '='; after it, both
    // instances must pulse done with the given result / error.
    task automatic run_expr(input string s, input int exp16, input int exp8, input bit exp_err);
        int spurious;
        spurious = 0;
        for (int i = 0; i < s.len(); i++) begin
            put(s[i]);
            if (i < s.len() - 1 && (bus16.done || bus8.done)) spurious++;
        end
        check({s, " early done"}, 32'(spurious), 32'd0);
        check({s, " done16"},     32'(bus16.done),   32'd1);
        check({s, " result16"},   32'(bus16.result), 32'(exp16));
        check({s, " error16"},    32'(bus16.error),  32'(exp_err));
        check({s, " done8"},      32'(bus8.done),    32'd1);
        check({s, " result8"},    32'(bus8.result),  32'(exp8));
        check({s, " error8"},     32'(bus8.error),   32'(exp_err));
    endtask

    initial begin
        checks = 0;
        errors = 0;
        clr_n  = 1'b0;
        bus16.in = 8'h00; bus16.in_valid = 1'b0;
        bus8.in  = 8'h00; bus8.in_valid  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset result", 32'(bus16.result), 32'd0);
        check("reset done",   32'(bus16.done),   32'd0);
        check("reset error",  32'(bus16.error),  32'd0);
        clr_n = 1'b1;

        run_expr("3+4*5=", 23, 23, 1'b0);
        idle();
        check("done pulse clears", 32'(bus16.done),   32'd0);
        check("result held",       32'(bus16.result), 32'd23);

        // 729 = 0x2D9 -> 217 in 8 bits.
        run_expr("9*9*9=", 729, 217, 1'b0);
        // 9^6 = 531441 -> 7153 mod 2^16, 241 mod 2^8.
        run_expr("9*9*9*9*9*9=", 7153, 241, 1'b0);
        run_expr("2*3+4*5+6=", 32, 32, 1'b0);

        run_expr("3+*4=", 0, 0, 1'b1);
        run_expr("2=", 2, 2, 1'b0);
        run_expr("3a+1=", 0, 0, 1'b1);
        run_expr("7+=", 0, 0, 1'b1);

`ifdef EXPR_EVAL_MULTIDIGIT_EN
        run_expr("12+3=", 15, 15, 1'b0);
`else
        run_expr("12+3=", 0, 0, 1'b1);
`endif

        // Back-to-back terminators: two consecutive error dones.
        run_expr("=", 0, 0, 1'b1);
        run_expr("=", 0, 0, 1'b1);
        run_expr("8=", 8, 8, 1'b0);

        // Gaps with in_valid low.
        put("2");
        for (int k = 0; k < 3; k++) begin
            idle();
            check("gap done", 32'(bus16.done), 32'd0);
        end
        run_expr("*7=", 14, 14, 1'b0);

        // Reset mid-expression discards "5+" and ignores the '9'.
        put("5");
        put("+");
        clr_n = 1'b0;
        put("9");
        check("reset mid done",   32'(bus16.done),   32'd0);
        check("reset mid result", 32'(bus16.result), 32'd0);
        clr_n = 1'b1;
        run_expr("6=", 6, 6, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/expr_eval.md
Name: expr_eval

Overview:
- Downstream companion to the character-stream expression recognizer.
- Consumes the same 8-bit ASCII stream, one character per accepted cycle.
- Computes the integer value of expressions of the form digit (op digit)*, where op is '+' or '*', and '*' binds tighter than '+'.
- Reports the value, plus a sticky-per-expression error flag, when the terminator '=' arrives. It then re-arms for the next expression.

Parameters:
- WIDTH, 16: width of result and internal accumulators; all arithmetic is modulo 2^WIDTH.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- clr_n  input  1  synchronous active-low reset, sampled on rising clk.
- in  input  8  ASCII character.
- in_valid  input  1  in is consumed on a rising edge only when in_valid=1.
- result  output  WIDTH  value of the last terminated expression; held until the next done.
- done  output  1  one-cycle pulse; expression terminated, result/error updated.
- error  output  1  last terminated expression was malformed; held until the next done.

Behaviour:
- Reset (clr_n=0 at posedge):
  - state=EXP_NUM, sum=0, prod=1, num=0.
  - result=0, done=0, error=0.
  - Reset overrides any in_valid on the same edge; a partial expression is discarded.
- Character classes: DIGIT ('0'..'9', value in-"0"), ADD ('+'), MUL ('*'), TERM ('='), OTHER (everything else).
- Accumulators:
  - sum: completed additive terms.
  - prod: product of completed factors in the current term.
  - num: current operand.
- State machine (advances only when in_valid=1; otherwise all state and outputs hold, except done, which clears):
  - EXP_NUM:
    - DIGIT -> num=d, go EXP_OP.
    - Any other class -> ERR; if it was TERM, terminate as an error (see below).
  - EXP_OP:
    - MUL -> prod=prod*num, go EXP_NUM.
    - ADD -> sum=sum+prod*num, prod=1, go EXP_NUM.
    - TERM -> result=sum+prod*num, error=0, done=1, then clear sum=0, prod=1, go EXP_NUM.
    - DIGIT -> ERR (base build).
    - OTHER -> ERR.
  - ERR:
    - Ignore all characters except TERM.
    - On TERM: result=0, error=1, done=1, clear accumulators, go EXP_NUM.
- Malformed expressions terminated by '=':
  - Applies to '=' in EXP_NUM (empty expression or trailing operator).
  - Same action as TERM in ERR: result=0, error=1, done=1, go EXP_NUM directly.
- Latency: done, result and error are registered. They are visible in the cycle after the edge that consumed '='.
- done is high for exactly one cycle, even if a second '=' arrives on the next cycle; that second '=' is an empty expression and produces another done with error=1.
- Overflow: products and sums truncate to WIDTH bits silently; no error is raised.
- A back-to-back '=' followed by a digit on the next cycle is legal; the new expression starts immediately.

Optional Feature:
- Macro: EXPR_EVAL_MULTIDIGIT_EN.
- Defined:
  - DIGIT in EXP_OP is legal: num=num*10+d (mod 2^WIDTH), stays in EXP_OP.
  - Operands may be multi-digit decimal numbers.
- Undefined:
  - DIGIT in EXP_OP -> ERR; operands are single digits only.
  - No multiply-by-10 logic is synthesized.

Test Plan:
- "3+4*5=" with in_valid=1 each cycle -> one done pulse the cycle after '=', result=23, error=0.
- WIDTH=8, "9*9*9=" -> result=217 (729 mod 256), error=0.
- "3+*4=" then "2=" -> first done with error=1, result=0; second done with error=0, result=2.
- "12+3=":
  - without EXPR_EVAL_MULTIDIGIT_EN -> error=1, result=0.
  - with it -> error=0, result=15.
- "2", in_valid=0 for 3 cycles (in driven 'x'), then "*", "7", "=" -> result=14, no done during gaps.
- "5+", then clr_n=0 for 1 cycle (in_valid=1, in="9"), then "6=" -> result=6, error=0; no done during or right after reset.
